regfile_scan_ctrl: RTL and testbench

- Multi-cycle initiator that sits on the debug side of the integer register file and drives one of its ports.
- Dump mode reads x0..x31 through the asynchronous read port and streams each word out on a valid/ready channel.
- Load mode accepts 32 words on a valid/ready channel and writes them through the write port.
- busy_o stalls the core pipeline so the register file is quiescent during a scan.

---
 rtl/regfile_scan_pkg.sv | 17 +
 rtl/regfile_scan_ctrl.sv | 117 +++++++++++
 tb/tb_regfile_scan_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_scan_pkg.sv
// regfile_scan_pkg: shared types, constants and checksum helper for the register file scan controller.
package regfile_scan_pkg;

    typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} scan_state_e;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;
    localparam int NREGS_DEF = 32;
    localparam int XLEN_DEF = 32;

    // Rotate-left-by-one then fold in the new word.
    function automatic logic [XLEN_DEF-1:0] cks_step(input logic [XLEN_DEF-1:0] c,
                                                     input logic [XLEN_DEF-1:0] w);
        return {c[XLEN_DEF-2:0], c[XLEN_DEF-1]} ^ w;
    endfunction

endpackage

// File: rtl/regfile_scan_ctrl.sv
// regfile_scan_ctrl: debug-side initiator that dumps or loads x0..x31 over valid/ready channels.
// Define REGFILE_SCAN_CHECKSUM_EN to build the rotate-XOR checksum over every scanned word.
module regfile_scan_ctrl
    import regfile_scan_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = 5,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [AW-1:0]   rf_addr_o,
    input  logic [XLEN-1:0] rf_rdata_i,
    output logic            rf_we_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_data_o,
    output logic [AW-1:0]   out_idx_o,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_data_i,
    output logic [XLEN-1:0] checksum_o
);

    scan_state_e     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            last;

    assign last       = idx_q == AW'(NREGS - 1);
    assign out_data_o = out_data_q;
    assign out_idx_o  = idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    // In DUMP the read port looks one register ahead so the next word is ready at the handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        busy_o      = state_q != IDLE;
        done_o      = 1'b0;
        rf_addr_o   = '0;
        rf_we_o     = 1'b0;
        rf_wdata_o  = '0;
        out_valid_o = 1'b0;
        in_ready_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d      = '0;
                    state_d    = mode_i == MODE_LOAD ? LOAD : DUMP;
                    out_data_d = mode_i == MODE_DUMP ? rf_rdata_i : out_data_q;
                end
            end
            DUMP: begin
                out_valid_o = 1'b1;
                rf_addr_o   = idx_q + 1'b1;
                if (out_ready_i) begin
                    state_d    = last ? DONE : DUMP;
                    idx_d      = last ? idx_q : idx_q + 1'b1;
                    out_data_d = last ? out_data_q : rf_rdata_i;
                end
            end
            LOAD: begin
                in_ready_o = 1'b1;
                rf_addr_o  = idx_q;
                rf_wdata_o = in_data_i;
                rf_we_o    = in_valid_i && (idx_q != '0);
                if (in_valid_i) begin
                    state_d = last ? DONE : LOAD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef REGFILE_SCAN_CHECKSUM_EN
    logic [XLEN-1:0] cks_q;
    logic            scan_hs;

    assign scan_hs    = (state_q == DUMP && out_ready_i) || (state_q == LOAD && in_valid_i);
    assign checksum_o = cks_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cks_q <= '0;
        else if (state_q == IDLE && start_i)
            cks_q <= '0;
        else if (scan_hs)
            cks_q <= cks_step(cks_q, state_q == DUMP ? out_data_q : in_data_i);
    end
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// tb_regfile_scan_ctrl: randomized dump/load scans of regfile_scan_ctrl against a register-array model.
module tb_regfile_scan_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start_i = 1'b0, mode_i = 1'b0, out_ready_i = 1'b0, in_valid_i = 1'b0;
    logic [31:0] in_data_i = '0;
    logic        busy_o, done_o, rf_we_o, out_valid_o, in_ready_o;
    logic [4:0]  rf_addr_o, out_idx_o;
    logic [31:0] rf_rdata_i, rf_wdata_o, out_data_o, checksum_o;

    logic [31:0] rf  [N];
    logic [31:0] mdl [N];
    int n_tests = 0, n_fail = 0;

    regfile_scan_ctrl dut (
        .clk(clk), .reset(reset), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .rf_addr_o(rf_addr_o), .rf_rdata_i(rf_rdata_i),
        .rf_we_o(rf_we_o), .rf_wdata_o(rf_wdata_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_idx_o(out_idx_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    // Register file stand-in: asynchronous read, x0 hardwired to zero, never reset.
    assign rf_rdata_i = rf_addr_o == 5'd0 ? 32'd0 : rf[rf_addr_o];
    always @(posedge clk) if (rf_we_o && rf_addr_o != 5'd0) rf[rf_addr_o] <= rf_wdata_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cks(input logic [31:0] w[$]);
        logic [31:0] c = '0;
`ifdef REGFILE_SCAN_CHECKSUM_EN
        foreach (w[i]) c = ((c << 1) | (c >> 31)) ^ w[i];
`endif
        return c;
    endfunction

    // pat: 0 = always ready, 1 = ready pattern 1-0-0-1, 2 = random ready; poke pulses start_i mid-scan and in DONE.
    task automatic dump(input int pat, input bit poke);
        logic [31:0] exp_w[$];
        logic [31:0] pd;
        logic [4:0]  pi;
        int k = 0, cyc = 0, dones = 0;
        bit stalled = 0;
        for (int i = 0; i < N; i++) exp_w.push_back(i == 0 ? 32'd0 : mdl[i]);
        start_i = 1; mode_i = 0;
        tick;
        start_i = 0;
        check("dump_busy", busy_o, 1);
        while (!done_o && cyc < 400) begin
            out_ready_i = pat == 0 ? 1'b1 : pat == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            start_i = poke && cyc == 5;
            mode_i = 1;
            #1;
            if (stalled) begin
                check("stall_idx", out_idx_o, pi);
                check("stall_data", out_data_o, pd);
            end
            check("dump_valid", out_valid_o, 1);
            check("dump_excl", {in_ready_o, rf_we_o}, 0);
            if (out_ready_i) begin
                check($sformatf("dump_idx%0d", k), out_idx_o, k);
                check($sformatf("dump_data%0d", k), out_data_o, k < N ? exp_w[k] : 32'hx);
                k++;
            end
            stalled = !out_ready_i;
            pi = out_idx_o;
            pd = out_data_o;
            tick;
            cyc++;
        end
        start_i = 0; mode_i = 0; out_ready_i = 0;
        check("dump_beats", k, N);
        check("dump_done", done_o, 1);
        if (pat == 0) check("dump_latency", cyc + 1, N + 1);
        check("dump_cks", checksum_o, exp_cks(exp_w));
        start_i = poke;
        tick;
        start_i = 0;
        check("dump_done_pulse", done_o, 0);
        check("dump_idle", busy_o, 0);
        repeat (3) begin
            tick;
            dones += int'(done_o);
        end
        check("dump_single_done", dones, 0);
        check("dump_still_idle", busy_o, 0);
        check("dump_cks_hold", checksum_o, exp_cks(exp_w));
    endtask

    // rnd: 0 = incrementing words with valid held high, 1 = random words and gaps; abort_at = beat index to reset at (-1 none).
    task automatic load(input bit rnd, input int abort_at);
        logic [31:0] words[$];
        int k = 0, cyc = 0;
        bit v;
        start_i = 1; mode_i = 1;
        tick;
        start_i = 0; mode_i = 0;
        while (!done_o && cyc < 400) begin
            if (k == abort_at) begin
                reset = 1;
                #1;
                check("abort_busy", busy_o, 0);
                check("abort_done", done_o, 0);
                check("abort_ready", in_ready_o, 0);
                check("abort_cks", checksum_o, 0);
                tick;
                reset = 0; in_valid_i = 0;
                return;
            end
            v = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
            in_valid_i = v;
            in_data_i = rnd ? $urandom : 32'h1000_0000 + k;
            #1;
            check("ld_we_x0", rf_we_o && rf_addr_o == 5'd0, 0);
            check("ld_ready", in_ready_o, 1);
            check("ld_no_valid", out_valid_o, 0);
            if (v) begin
                check($sformatf("ld_addr%0d", k), rf_addr_o, k);
                check($sformatf("ld_we%0d", k), rf_we_o, k != 0);
                words.push_back(in_data_i);
                if (k > 0 && k < N) mdl[k] = in_data_i;
                k++;
            end else check("ld_we_idle", rf_we_o, 0);
            tick;
            cyc++;
        end
        in_valid_i = 0;
        check("ld_beats", k, N);
        check("ld_done", done_o, 1);
        if (!rnd) check("ld_latency", cyc + 1, N + 1);
        check("ld_cks", checksum_o, exp_cks(words));
        tick;
        check("ld_done_pulse", done_o, 0);
        check("ld_idle", busy_o, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rf[i]  = i == 0 ? 32'd0 : 32'd4;
            mdl[i] = i == 0 ? 32'd0 : 32'd4;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_outs", {done_o, rf_we_o, out_valid_o, in_ready_o}, 0);
        check("rst_data", out_data_o, 0);
        check("rst_idx", out_idx_o, 0);
        check("rst_cks", checksum_o, 0);
        reset = 0;
        tick;
        check("idle_addr", rf_addr_o, 0);
        dump(0, 0);
        load(0, -1);
        dump(0, 0);
        dump(1, 0);
        dump(2, 1);
        load(1, -1);
        dump(2, 0);
        load(1, 10);
        dump(0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
